// File: rtl/mulu_pkg.sv
// Shared constants and types for the 7x7 unsigned sequential multiplier tile.
package mulu_pkg;

    localparam int unsigned W     = 7;
    localparam int unsigned PW    = 14;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        DONE
    } state_e;

    localparam int unsigned IDX_CLK    = 0;
    localparam int unsigned IDX_RST    = 1;
    localparam int unsigned IDX_START  = 2;
    localparam int unsigned IDX_M_IN   = 3;
    localparam int unsigned IDX_Q_IN   = 4;
    localparam int unsigned IDX_HI_SEL = 5;

endpackage

// File: rtl/mulu_m7q7_core_if.sv
// Tile pin bundle: 8 input pins toward the core, 8 output pins back.
interface mulu_m7q7_core_if;

    logic [7:0] io_in;
    logic [7:0] io_out;

    modport master (output io_in, input io_out);
    modport slave  (input io_in, output io_out);

endinterface

// File: rtl/mulu_m7q7_core_shift_add_dp.sv
// Multiplicand register and product/shift-add datapath.
// MULU_NEGEDGE_EN moves all state updates to the falling clock edge.
module mulu_shift_add_dp
    import mulu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          shift_en,
    input  logic          m_bit,
    input  logic          init_en,
    input  logic [W-1:0]  q_val,
    input  logic          step_en,
    output logic [PW-1:0] p
);

    logic [W-1:0]  m_q;
    logic [PW-1:0] p_q;
    logic [W:0]    sum;

    // s[7] carries into the product top bit; keep the full 8-bit sum.
    always_comb begin
        sum = {1'b0, p_q[PW-1:W]} + (p_q[0] ? {1'b0, m_q} : '0);
    end

`ifdef MULU_NEGEDGE_EN
    always_ff @(negedge clk or posedge rst) begin
`else
    always_ff @(posedge clk or posedge rst) begin
`endif
        if (rst) begin
            m_q <= '0;
            p_q <= '0;
        end else begin
            if (shift_en) begin
                m_q <= {m_bit, m_q[W-1:1]};
            end
            if (init_en) begin
                p_q <= {{W{1'b0}}, q_val};
            end else if (step_en) begin
                p_q <= {sum, p_q[W-1:1]};
            end
        end
    end

    assign p = p_q;

endmodule

// File: rtl/mulu_m7q7_core.sv
// 7x7 unsigned sequential multiplier tile top: FSM, bit counter, multiplier shift-in, output mux.
// MULU_NEGEDGE_EN moves all state updates to the falling clock edge.
module mulu_m7q7_core
    import mulu_pkg::*;
(
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    logic clk, rst, start, m_in, q_in, hi_sel;
    logic unused_pins;

    assign clk         = io_in[IDX_CLK];
    assign rst         = io_in[IDX_RST];
    assign start       = io_in[IDX_START];
    assign m_in        = io_in[IDX_M_IN];
    assign q_in        = io_in[IDX_Q_IN];
    assign hi_sel      = io_in[IDX_HI_SEL];
    assign unused_pins = ^io_in[7:6];

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     mplier_q;
    logic             done_q;
    logic [W-1:0]     q_shift;
    logic             last;
    logic             shift_en, init_en, step_en;
    logic [PW-1:0]    p;

    assign q_shift  = {q_in, mplier_q[W-1:1]};
    assign last     = (cnt_q == CNT_W'(W - 1));
    assign shift_en = (state_q == LOAD);
    // The 7th load edge seeds P with the fully shifted multiplier, including this edge's bit.
    assign init_en  = shift_en && last;
    assign step_en  = (state_q == CALC);

`ifdef MULU_NEGEDGE_EN
    always_ff @(negedge clk or posedge rst) begin
`else
    always_ff @(posedge clk or posedge rst) begin
`endif
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mplier_q <= '0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LOAD;
                        cnt_q   <= '0;
                    end
                end
                LOAD: begin
                    mplier_q <= q_shift;
                    if (last) begin
                        cnt_q   <= '0;
                        state_q <= CALC;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                CALC: begin
                    if (last) begin
                        cnt_q   <= '0;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (start) begin
                        done_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= LOAD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mulu_shift_add_dp u_dp (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .m_bit    (m_in),
        .init_en  (init_en),
        .q_val    (q_shift),
        .step_en  (step_en),
        .p        (p)
    );

    assign io_out = {done_q, hi_sel ? p[PW-1:W] : p[W-1:0]};

endmodule

// File: tb/tb_mulu_m7q7_core.sv
// Self-checking bench for mulu_m7q7_core; expected products queued at start, checked at done.
// Build with MULU_NEGEDGE_EN to exercise the falling-edge variant.
module tb_mulu_m7q7_core;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic start  = 1'b0;
    logic m_in   = 1'b0;
    logic q_in   = 1'b0;
    logic hi_sel = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [13:0] exp_q[$];

    mulu_m7q7_core_if pins ();

    assign pins.io_in = {2'b00, hi_sel, q_in, m_in, start, rst, clk};

    mulu_m7q7_core dut (
        .io_in  (pins.io_in),
        .io_out (pins.io_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic step_edge();
`ifdef MULU_NEGEDGE_EN
        @(negedge clk);
`else
        @(posedge clk);
`endif
        #1;
    endtask

    task automatic load_operands(input logic [6:0] a, input logic [6:0] b);
        start = 1'b1;
        step_edge();
        start = 1'b0;
        check_val("done_clr", pins.io_out & 8'h80, 8'h00);
        for (int i = 0; i < 7; i++) begin
            m_in = a[i];
            q_in = b[i];
            step_edge();
        end
        m_in = 1'($urandom);
        q_in = 1'($urandom);
    endtask

    task automatic run_mul(input logic [6:0] a, input logic [6:0] b, input bit pulse);
        logic [13:0] e;
        exp_q.push_back({7'b0, a} * {7'b0, b});
        load_operands(a, b);
        for (int i = 0; i < 6; i++) begin
            start = pulse && (i == 2);
            step_edge();
        end
        start = 1'b0;
        check_val("busy_e14", pins.io_out & 8'h80, 8'h00);
        step_edge();
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_empty: got empty queue expected one entry");
        end else begin
            e = exp_q.pop_front();
            hi_sel = 1'b0;
            #1;
            check_val("lo", pins.io_out, {1'b1, e[6:0]});
            hi_sel = 1'b1;
            #1;
            check_val("hi", pins.io_out, {1'b1, e[13:7]});
        end
    endtask

    initial begin
        #1;
        check_val("rst_hold", pins.io_out, 8'h00);
        step_edge();
        step_edge();
        #2;
        rst = 1'b0;
        #1;
        check_val("rst_rel", pins.io_out, 8'h00);
        step_edge();
        check_val("idle", pins.io_out, 8'h00);

        run_mul(7'd5, 7'd3, 1'b0);
        run_mul(7'd127, 7'd127, 1'b0);
        run_mul(7'd100, 7'd77, 1'b0);
        run_mul(7'd0, 7'd127, 1'b1);
        run_mul(7'd12, 7'd10, 1'b0);

        // Abort mid-CALC with an asynchronous reset, away from any clock edge.
        load_operands(7'd100, 7'd77);
        step_edge();
        step_edge();
        step_edge();
        #2;
        rst = 1'b1;
        #1;
        hi_sel = 1'b1;
        #1;
        check_val("rst_async_hi", pins.io_out, 8'h00);
        hi_sel = 1'b0;
        #1;
        check_val("rst_async_lo", pins.io_out, 8'h00);
        step_edge();
        rst = 1'b0;
        #1;
        check_val("rst_after", pins.io_out, 8'h00);
        run_mul(7'd9, 7'd13, 1'b0);

        for (int k = 0; k < 6; k++) begin
            run_mul(7'($urandom), 7'($urandom), (k % 2) == 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
